// File: rtl/fetch_byte_stream.sv
// Instruction byte streamer: fetches aligned 64-bit words into a small FIFO and emits one byte plus PC per cycle.
// Define FETCH_BYPASS_EN to forward a response straight to inst when the FIFO is empty (0-cycle latency).
module fetch_byte_stream #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [63:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        inst,
  output logic [ADDR_W-1:0] pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RESET_BASE = {RESET_PC[ADDR_W-1:3], 3'b000};

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [63:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     drop_cnt_next;
  logic [CW:0]       credit_used;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [ADDR_W-1:0] redirect_base;
  logic [2:0]        byte_off;
  logic              req_enable;

  logic              in_flush;
  logic              req_fire;
  logic              rsp_live;
  logic              rsp_drop;
  logic              rsp_accept;
  logic              consume;
  logic              push;
  logic              pop;
  logic [63:0]       head_word;
  logic [ADDR_W-1:0] head_addr;

  // Requests are gated by a credit check so an issued word always has a FIFO slot waiting for it.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = req_enable && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_addr;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_base  = {redirect_pc[ADDR_W-1:3], 3'b000};

  // A response with nothing outstanding can only be left over from before a reset, so it is ignored.
  assign rsp_live   = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop   = rsp_live && in_flush;
  assign rsp_accept = rsp_live && !in_flush && !redirect_valid;
  assign push       = rsp_accept;
  assign consume    = inst_valid && inst_ready && !redirect_valid;
  assign pop        = consume && (byte_off == 3'd7);

  always_comb begin
    drop_cnt_next = drop_cnt;
    if (redirect_valid) begin
      drop_cnt_next = outstanding - CW'(rsp_live);
    end else if (rsp_drop) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (drop_cnt_next != '0) state_next = S_FLUSH;
      S_FLUSH: if (drop_cnt_next == '0) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  always_comb begin
    in_flush = (state == S_FLUSH);
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = (count == '0) && rsp_accept;

  always_comb begin
    inst_valid = (count != '0) || bypass;
    head_word  = bypass ? imem_rsp_data : fifo_data[rd_ptr];
    head_addr  = bypass ? rsp_addr : fifo_addr[rd_ptr];
  end
`else
  always_comb begin
    inst_valid = (count != '0);
    head_word  = fifo_data[rd_ptr];
    head_addr  = fifo_addr[rd_ptr];
  end
`endif

  // Outputs are forced to zero whenever no byte is presented, which also covers the reset state.
  always_comb begin
    inst = 8'h00;
    pc   = '0;
    if (inst_valid) begin
      inst = head_word[{byte_off, 3'b000} +: 8];
      pc   = head_addr | {{(ADDR_W-3){1'b0}}, byte_off};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_enable  <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_addr  <= RESET_BASE;
      rsp_addr    <= RESET_BASE;
      byte_off    <= RESET_PC[2:0];
    end else begin
      req_enable  <= 1'b1;
      drop_cnt    <= drop_cnt_next;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
      if (redirect_valid) begin
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fetch_addr <= redirect_base;
        rsp_addr   <= redirect_base;
        byte_off   <= redirect_pc[2:0];
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (req_fire) fetch_addr <= fetch_addr + ADDR_W'(8);
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          rsp_addr <= rsp_addr + ADDR_W'(8);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (consume) byte_off <= byte_off + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_addr[wr_ptr] <= rsp_addr;
    end
  end

endmodule

// File: tb/tb_fetch_byte_stream.sv
// Self-checking bench for fetch_byte_stream: memory model with controllable latency/budget and a byte scoreboard.
module tb_fetch_byte_stream;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst;
  logic [31:0] pc;

  typedef struct {
    logic [7:0]  b;
    logic [31:0] p;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    int          t;
  } req_t;

  exp_t sb[$];
  req_t mem_pend[$];
  int   cons_cyc[$];
  int   cyc = 0;
  int   req_fires = 0;
  int   mem_budget = -1;
  int   mem_lat = 1;
  int   n_compared = 0;
  int   n_mismatched = 0;
  bit   saw_valid = 1'b0;

  fetch_byte_stream #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [63:0] word_at(input logic [31:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(a + 32'(k));
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Loads the scoreboard with the byte stream expected from 'start' and optionally raises a redirect to it.
  task automatic applyStimulus(input bit do_redirect, input logic [31:0] start, input int n);
    if (do_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = start;
    end
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back('{b: mem_byte(start + 32'(i)), p: start + 32'(i)});
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    mem_budget     = -1;
    mem_pend.delete();
    sb.delete();
    cons_cyc.delete();
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    req_fires = 0;
    saw_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    inst_ready = 1'b0;
    checkOutput({"drain_", tag}, 64'(sb.size()), 64'd0);
  endtask

  task automatic waitFires(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && req_fires < n; i++) @(negedge clk);
    checkOutput({"fires_", tag}, 64'(req_fires), 64'(n));
  endtask

  // Memory: responds in order once each request's latency has elapsed, limited by mem_budget (-1 = unlimited).
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rstn && mem_pend.size() != 0 && mem_pend[0].t <= cyc && mem_budget != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(mem_pend[0].a);
        void'(mem_pend.pop_front());
        if (mem_budget > 0) mem_budget--;
      end
    end
  end

  // Monitor: samples one time unit before each rising edge, records requests and scores consumed bytes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rstn) begin
        if (imem_req_valid && imem_req_ready) begin
          mem_pend.push_back('{a: imem_req_addr, t: cyc + mem_lat});
          req_fires++;
        end
        if (inst_valid) saw_valid = 1'b1;
        if (inst_valid && inst_ready && !redirect_valid) begin
          cons_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checkOutput("unexpected_byte_pc", {32'h0, pc}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            checkOutput("inst_byte", {56'h0, inst}, {56'h0, e.b});
            checkOutput("inst_pc", {32'h0, pc}, {32'h0, e.p});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("reset_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("reset_inst", 64'(inst), 64'd0);
    checkOutput("reset_pc", 64'(pc), 64'd0);
    checkOutput("reset_state", 64'(dut.state), 64'd0);

    // Straight-line stream from RESET_PC, one byte per cycle.
    applyStimulus(1'b0, 32'h0, 16);
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    rstn           = 1'b1;
    waitDrain("stream", 80);
    checkOutput("stream_count", 64'(cons_cyc.size()), 64'd16);
    if (cons_cyc.size() >= 16) checkOutput("stream_span", 64'(cons_cyc[15] - cons_cyc[0]), 64'd15);

    // Consumer stalled for 40 cycles: issue stops at DEPTH credits, data survives.
    applyReset();
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32);
    repeat (40) @(negedge clk);
    checkOutput("stall_fires", 64'(req_fires), 64'd4);
    checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("stall_inst_valid", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    waitDrain("stall", 150);
    mem_lat = 1;

    // Redirect with three requests in flight: all three responses must be dropped.
    applyReset();
    mem_budget     = 0;
    imem_req_ready = 1'b1;
    waitFires("redir3", 3, 20);
    imem_req_ready = 1'b0;
    checkOutput("redir_pre_state", 64'(dut.state), 64'd0);
    applyStimulus(1'b1, 32'h1005, 11);
    @(negedge clk);
    redirect_valid = 1'b0;
    checkOutput("redir_flush_state", 64'(dut.state), 64'd1);
    checkOutput("redir_drop_cnt", 64'(dut.drop_cnt), 64'd3);
    checkOutput("redir_inst_valid", 64'(inst_valid), 64'd0);
    mem_budget     = -1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    waitDrain("redir", 100);
    checkOutput("redir_run_state", 64'(dut.state), 64'd0);

    // Redirect, consume and response all in the same cycle.
    applyReset();
    mem_budget     = 0;
    imem_req_ready = 1'b1;
    waitFires("same3", 3, 20);
    imem_req_ready = 1'b0;
    mem_budget     = 1;
    repeat (3) @(negedge clk);
    checkOutput("same_pre_valid", 64'(inst_valid), 64'd1);
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    mem_budget     = 1;
    applyStimulus(1'b1, 32'h2003, 13);
    #4;
    checkOutput("same_no_req", 64'(imem_req_valid), 64'd0);
    checkOutput("same_inst_valid", 64'(inst_valid), 64'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    checkOutput("same_drop_cnt", 64'(dut.drop_cnt), 64'd1);
    checkOutput("same_flush_state", 64'(dut.state), 64'd1);
    checkOutput("same_inst_cleared", 64'(inst_valid), 64'd0);
    mem_budget = -1;
    waitDrain("same", 100);

    // Asynchronous reset mid-stream with two responses still pending.
    applyReset();
    mem_budget     = 0;
    imem_req_ready = 1'b1;
    waitFires("rst4", 4, 20);
    imem_req_ready = 1'b0;
    mem_budget     = 2;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5);
    inst_ready = 1'b1;
    waitDrain("rst_pre", 30);
    checkOutput("rst_pre_valid", 64'(inst_valid), 64'd1);
    checkOutput("rst_pre_pc", 64'(pc), 64'd5);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_async_req", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_async_pc", 64'(pc), 64'd0);
    checkOutput("rst_async_inst", 64'(inst), 64'd0);
    mem_budget = -1;
    @(negedge clk);
    rstn      = 1'b1;
    saw_valid = 1'b0;
    req_fires = 0;
    for (int i = 0; i < 20 && mem_pend.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("rst_late_pending", 64'(mem_pend.size()), 64'd0);
    checkOutput("rst_late_dropped", 64'(saw_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 16);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    waitDrain("rst_restart", 100);

    // Response-to-inst latency from an empty FIFO, after a redirect with nothing in flight.
    applyReset();
    mem_budget = 0;
    applyStimulus(1'b1, 32'h3002, 6);
    @(negedge clk);
    redirect_valid = 1'b0;
    checkOutput("lat_state", 64'(dut.state), 64'd0);
    imem_req_ready = 1'b1;
    waitFires("lat1", 1, 20);
    imem_req_ready = 1'b0;
    mem_budget     = 1;
    #4;
    checkOutput("lat_same_cycle_valid", 64'(inst_valid), 64'(BYP));
    @(negedge clk);
    #4;
    checkOutput("lat_next_valid", 64'(inst_valid), 64'd1);
    checkOutput("lat_inst", 64'(inst), 64'h32);
    checkOutput("lat_pc", 64'(pc), 64'h3002);
    @(negedge clk);
    mem_budget     = -1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    waitDrain("lat", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
